ids_bus_arbiter: RTL and testbench
==================================

# ids_bus_arbiter

Round-robin bus arbiter with hold-limit and lock for shared SRAM/peripheral bus ports. Resolves `req`/`gnt` between the core data port, the PIM DMA engine and any later masters, and gives exactly one owner access to the bus. It inserts a one-cycle drain on every ownership change so that the 1-cycle-latency DMEM/UART read data returns to the previous owner. It also provides a registered response select for the read-data return mux.

## Interface

Parameters:
- `NUM_REQ`, default 2: number of requesters, 2..8. Index 0 is the core DMEM port, index 1 is the DMA.
- `MAX_HOLD`, default 16: maximum consecutive granted cycles while others wait and the owner is unlocked. Must be ≥ 1.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester index.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: reset, asynchronous, active-high.
- `i_req`, in, `NUM_REQ`: per-requester bus request, level.
- `i_lock`, in, `NUM_REQ`: per-requester lock; the owner keeps the bus regardless of `MAX_HOLD`.
- `o_gnt`, out, `NUM_REQ`: one-hot grant (all zero when no owner). Registered.
- `o_gnt_id`, out, `ID_W`: index of the current owner; 0 when there is no owner.
- `o_busy`, out, 1: state ≠ IDLE.
- `o_rsp_valid`, out, 1: the read-response slot this cycle belongs to a granted access.
- `o_rsp_sel`, out, `ID_W`: requester that should receive bus read data this cycle.
- `o_preempt`, out, 1: one-cycle pulse in the DRAIN cycle caused by hold-limit expiry.

## Operation

- **State.** FSM with three states: IDLE, OWN, DRAIN. Registers:
  - `owner` (`ID_W`)
  - `last` (`ID_W`): previous winner
  - `hold_cnt` (`$clog2(MAX_HOLD)`, min 1 bit)
- **Winner selection.** The winner is the first requester with `i_req` set, scanning `last+1`, `last+2`, … modulo `NUM_REQ`.
- **IDLE.**
  - If `|i_req`: go to OWN with `owner` = winner, `last` = winner, `hold_cnt` = 0.
  - Otherwise stay in IDLE.
- **OWN.** `o_gnt[owner]` = 1. `hold_cnt` increments each cycle and saturates at `MAX_HOLD-1`. Define `others = |(i_req & ~(1<<owner))`. Transitions are evaluated in this order:
  1. `!i_req[owner]`: if `others`, go to DRAIN; else go to IDLE.
  2. `i_lock[owner]`: stay in OWN. Lock is ignored for non-owners.
  3. `hold_cnt == MAX_HOLD-1 && others`: go to DRAIN and set the preempt flag.
  4. Otherwise stay in OWN.
- **DRAIN.** All grants are 0 for exactly one cycle. At the end of the cycle, re-arbitrate using the current `i_req` and `last`:
  - If there is a winner, go to OWN with `hold_cnt` = 0. A preempted owner still requesting is eligible, but round-robin places it last.
  - If there is no winner, go to IDLE.
- **Response select.**
  - `o_rsp_valid` = registered `|o_gnt`.
  - `o_rsp_sel` = registered `o_gnt_id`.
  - Both follow the grant by exactly one cycle, including through DRAIN and into IDLE.
- **Reset values** (`i_rst` high, effective immediately):
  - State = IDLE, `last` = `NUM_REQ-1` (so requester 0 wins first), `owner` = 0, `hold_cnt` = 0.
  - Every output = 0.
  - Reset mid-grant drops `o_gnt` without waiting for a clock edge; no drain is performed.

## Timing

- **Request to grant.** `i_req` rising at edge *t* in IDLE gives `o_gnt` high after edge *t+1*. No combinational path from `i_req` to `o_gnt`.
- **Release.** Owner drops `i_req` in cycle *c*: `o_gnt` goes low at *c+1*. During the grant, a requester may only issue bus commands in cycles where its `o_gnt` is high.
- **Ownership change.** Always costs exactly one DRAIN cycle between different owners or successive grants. No back-to-back grants without a gap, except an uninterrupted OWN.
- **Hold limit.** With others waiting, an unlocked owner holds at most `MAX_HOLD` consecutive cycles. A lock released in a cycle where `hold_cnt` is saturated and others are waiting preempts at the next edge.
- **`o_preempt`.** High only in a DRAIN cycle entered via rule 3, never at the same time as any `o_gnt` bit.
- **Simultaneous events.** Owner drop and hold expiry in the same cycle count as a release (rule 1); `o_preempt` stays 0.

## Test plan

1. **Single request.** Reset, then `i_req`=01 at cycle 0 → `o_gnt`=01 from cycle 1, `o_busy`=1. `o_rsp_valid`=1 with `o_rsp_sel`=0 from cycle 2. Drop `i_req` at cycle 5 → `o_gnt`=00 at 6, `o_rsp_valid`=0 at 7, `o_busy`=0 at 6.
2. **Contention with hold limit.** `MAX_HOLD`=4, `i_req`=11 held from cycle 0 → `o_gnt`=01 cycles 1–4. DRAIN at 5 with `o_preempt`=1. `o_gnt`=10 cycles 6–9. DRAIN at 10. `o_gnt`=01 from 11.
3. **Lock.** `MAX_HOLD`=4, requester 1 owns with `i_lock[1]`=1 while `i_req[0]`=1 → grant held 20 cycles. Drop lock → DRAIN with `o_preempt`=1 on the next cycle, then `o_gnt`=01.
4. **Voluntary release while the other waits.** Owner 0 drops `i_req` → DRAIN with `o_preempt`=0. `o_rsp_sel`=0 and `o_rsp_valid`=1 during DRAIN. `o_gnt`=10 next cycle.
5. **Asynchronous reset mid-OWN.** Raise `i_rst` mid-cycle while `o_gnt`=10 → all outputs 0 before the next edge. Release reset with `i_req`=11 → requester 0 is granted first.
6. **Three-way rotation.** `NUM_REQ`=3, `MAX_HOLD`=1, `i_req`=111 → grant order 0,1,2,0,… with one DRAIN between each and `o_preempt`=1 in every DRAIN.

Source files
------------

// File: rtl/ids_bus_arbiter_if.sv
// Bus-arbiter signal bundle: per-requester request/lock in, grant and
// response-select out. The arbiter takes the slave side, requesters the master.
interface ids_bus_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0] i_req;
    logic [NUM_REQ-1:0] i_lock;
    logic [NUM_REQ-1:0] o_gnt;
    logic [ID_W-1:0]    o_gnt_id;
    logic               o_busy;
    logic               o_rsp_valid;
    logic [ID_W-1:0]    o_rsp_sel;
    logic               o_preempt;

    modport master (
        output i_req, i_lock,
        input  o_gnt, o_gnt_id, o_busy, o_rsp_valid, o_rsp_sel, o_preempt
    );

    modport slave (
        input  i_req, i_lock,
        output o_gnt, o_gnt_id, o_busy, o_rsp_valid, o_rsp_sel, o_preempt
    );
endinterface

// File: rtl/ids_bus_arbiter.sv
// Round-robin bus arbiter with hold limit and owner lock. Every ownership
// change passes through a one-cycle DRAIN so that 1-cycle-latency read data
// still returns to the previous owner; o_rsp_valid/o_rsp_sel follow the
// grant by one cycle to steer that read data.
module ids_bus_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int MAX_HOLD = 16,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    ids_bus_arbiter_if.slave  bus
);
    localparam int                HC_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HC_W-1:0]   HOLD_MAX = HC_W'(MAX_HOLD - 1);
    localparam logic [ID_W-1:0]   LAST_RST = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     owner_q, owner_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic [HC_W-1:0]     hold_q, hold_d;
    logic                preempt_q, preempt_d;
    logic                rsp_valid_q;
    logic [ID_W-1:0]     rsp_sel_q;

    logic [ID_W-1:0]     win_id;
    logic                win_found;
    logic [NUM_REQ-1:0]  owner_mask;
    logic                own_req;
    logic                own_lock;
    logic                others;
    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_id;

    assign owner_mask = NUM_REQ'(1) << owner_q;
    assign own_req    = |(bus.i_req  & owner_mask);
    assign own_lock   = |(bus.i_lock & owner_mask);
    assign others     = |(bus.i_req  & ~owner_mask);

    // Round-robin pick: the requester closest after `last` (distance 0 is last+1).
    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        int best_d;
        int d;
        win_id    = '0;
        win_found = 1'b0;
        best_d    = NUM_REQ;
        for (int j = 0; j < NUM_REQ; j++) begin
            d = (j - int'(last_q) + NUM_REQ - 1) % NUM_REQ;
            if (bus.i_req[ID_W'(j)] && d < best_d) begin
                best_d    = d;
                win_id    = ID_W'(j);
                win_found = 1'b1;
            end
        end
    end

    // Next-state logic: arbitration from IDLE/DRAIN, release/lock/hold rules in OWN.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DRAIN: begin
                if (win_found) begin
                    state_d = ST_OWN;
                    owner_d = win_id;
                    last_d  = win_id;
                    hold_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HC_W'(1);
                end
                if (!own_req) begin
                    state_d = others ? ST_DRAIN : ST_IDLE;
                end else if (own_lock) begin
                    state_d = ST_OWN;
                end else if (hold_q == HOLD_MAX && others) begin
                    state_d   = ST_DRAIN;
                    preempt_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Arbiter state and one-cycle-delayed response select.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            last_q      <= LAST_RST;
            hold_q      <= '0;
            preempt_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            preempt_q   <= preempt_d;
            rsp_valid_q <= |gnt;
            rsp_sel_q   <= gnt_id;
        end
    end

    // Grant is decoded purely from registered state; reset clears it at once.
    assign gnt    = (state_q == ST_OWN) ? owner_mask : '0;
    assign gnt_id = (state_q == ST_OWN) ? owner_q : '0;

    assign bus.o_gnt       = gnt;
    assign bus.o_gnt_id    = gnt_id;
    assign bus.o_busy      = (state_q != ST_IDLE);
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_sel   = rsp_sel_q;
    assign bus.o_preempt   = preempt_q;
endmodule

// File: tb/tb_ids_bus_arbiter.sv
// Bench for ids_bus_arbiter: a 2-requester/MAX_HOLD=4 instance and a
// 3-requester/MAX_HOLD=1 instance, checked cycle by cycle against an
// owner/run-length model plus fixed expectations for the directed scenarios.
module tb_ids_bus_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ids_bus_arbiter_if #(.NUM_REQ(2)) bus2 ();
    ids_bus_arbiter_if #(.NUM_REQ(3)) bus3 ();

    ids_bus_arbiter #(.NUM_REQ(2), .MAX_HOLD(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus2)
    );

    ids_bus_arbiter #(.NUM_REQ(3), .MAX_HOLD(1)) dut3 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus3)
    );

    always #5 clk = ~clk;

    // Observed outputs packed as {gnt[4], id[4], busy, rsp_valid, rsp_sel[4], preempt}.
    logic [14:0] obs2, obs3;
    assign obs2 = {2'b0, bus2.o_gnt, 3'b0, bus2.o_gnt_id, bus2.o_busy,
                   bus2.o_rsp_valid, 3'b0, bus2.o_rsp_sel, bus2.o_preempt};
    assign obs3 = {1'b0, bus3.o_gnt, 2'b0, bus3.o_gnt_id, bus3.o_busy,
                   bus3.o_rsp_valid, 2'b0, bus3.o_rsp_sel, bus3.o_preempt};

    // Model: current owner (-1 = nobody), number of cycles it has held the bus,
    // previous winner, whether the ownerless cycle is a drain, and the preempt flag.
    int m_cur  [2];
    int m_run  [2];
    int m_prev [2];
    int m_rs   [2];
    bit m_gap  [2];
    bit m_pre  [2];
    bit m_rv   [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cur[k]  = -1;
            m_run[k]  = 0;
            m_prev[k] = (k == 0) ? 1 : 2;
            m_rs[k]   = 0;
            m_gap[k]  = 1'b0;
            m_pre[k]  = 1'b0;
            m_rv[k]   = 1'b0;
        end
    endtask

    task automatic model_advance(input int k, input logic [3:0] req, input logic [3:0] lock);
        int   n;
        int   mh;
        int   w;
        bit   oth;
        n  = (k == 0) ? 2 : 3;
        mh = (k == 0) ? 4 : 1;
        m_rv[k] = (m_cur[k] >= 0);
        m_rs[k] = (m_cur[k] >= 0) ? m_cur[k] : 0;
        if (m_cur[k] < 0) begin
            m_pre[k] = 1'b0;
            m_gap[k] = 1'b0;
            w = -1;
            for (int i = 1; i <= n; i++) begin
                if (w < 0 && req[2'((m_prev[k] + i) % n)]) w = (m_prev[k] + i) % n;
            end
            if (w >= 0) begin
                m_cur[k]  = w;
                m_prev[k] = w;
                m_run[k]  = 1;
            end
        end else begin
            oth = (req & ~(4'b0001 << m_cur[k])) != 4'b0;
            if (!req[2'(m_cur[k])]) begin
                m_cur[k] = -1;
                m_gap[k] = oth;
            end else if (!lock[2'(m_cur[k])] && m_run[k] >= mh && oth) begin
                m_cur[k] = -1;
                m_gap[k] = 1'b1;
                m_pre[k] = 1'b1;
            end else begin
                m_run[k]++;
            end
        end
    endtask

    function automatic logic [14:0] exp_vec(input int k);
        logic [3:0] g;
        logic [3:0] id;
        logic       busy;
        g  = '0;
        id = '0;
        if (m_cur[k] >= 0) begin
            g  = 4'b0001 << m_cur[k];
            id = 4'(m_cur[k]);
        end
        busy = (m_cur[k] >= 0) || m_gap[k];
        return {g, id, busy, m_rv[k], 4'(m_rs[k]), m_pre[k]};
    endfunction

    // Advance both models with the inputs of the current cycle, then cross the edge.
    task automatic tick();
        model_advance(0, {2'b0, bus2.i_req}, {2'b0, bus2.i_lock});
        model_advance(1, {1'b0, bus3.i_req}, {1'b0, bus3.i_lock});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus2.i_req  = '0;
        bus2.i_lock = '0;
        bus3.i_req  = '0;
        bus3.i_lock = '0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus2.i_req  = '0;
        bus2.i_lock = '0;
        bus3.i_req  = '0;
        bus3.i_lock = '0;
        rst = 1'b1;
        #1;
        checks++;
        if (obs2 !== 15'b0) begin
            failures++;
            $display("FAIL reset_outputs_2 got=%h exp=0", obs2);
        end
        checks++;
        if (obs3 !== 15'b0) begin
            failures++;
            $display("FAIL reset_outputs_3 got=%h exp=0", obs3);
        end
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (obs2 !== exp_vec(0) || obs3 !== exp_vec(1)) begin
                failures++;
                $display("FAIL reset_idle c%0d got=%h/%h exp=%h/%h", c, obs2, obs3, exp_vec(0), exp_vec(1));
            end
            tick();
        end
    endtask

    task automatic test_single();
        logic [1:0] exp_g;
        do_reset();
        bus2.i_req = 2'b01;
        for (int c = 0; c < 9; c++) begin
            if (c == 5) bus2.i_req = 2'b00;
            @(negedge clk);
            exp_g = (c >= 1 && c <= 5) ? 2'b01 : 2'b00;
            checks++;
            if (bus2.o_gnt !== exp_g) begin
                failures++;
                $display("FAIL single_gnt c%0d got=%b exp=%b", c, bus2.o_gnt, exp_g);
            end
            checks++;
            if (obs2 !== exp_vec(0)) begin
                failures++;
                $display("FAIL single_model c%0d got=%h exp=%h", c, obs2, exp_vec(0));
            end
            tick();
        end
    endtask

    task automatic test_hold_limit();
        logic [1:0] exp_g;
        logic       exp_p;
        do_reset();
        bus2.i_req = 2'b11;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            exp_g = ((c >= 1 && c <= 4) || c >= 11) ? 2'b01 :
                    (c >= 6 && c <= 9) ? 2'b10 : 2'b00;
            exp_p = (c == 5 || c == 10);
            checks++;
            if (bus2.o_gnt !== exp_g || bus2.o_preempt !== exp_p) begin
                failures++;
                $display("FAIL hold_limit c%0d got gnt=%b pre=%b exp gnt=%b pre=%b",
                         c, bus2.o_gnt, bus2.o_preempt, exp_g, exp_p);
            end
            checks++;
            if (obs2 !== exp_vec(0)) begin
                failures++;
                $display("FAIL hold_model c%0d got=%h exp=%h", c, obs2, exp_vec(0));
            end
            tick();
        end
    endtask

    task automatic test_lock();
        logic [1:0] exp_g;
        logic       exp_p;
        do_reset();
        bus2.i_req = 2'b10;
        for (int c = 0; c < 25; c++) begin
            if (c == 1) begin
                bus2.i_req  = 2'b11;
                bus2.i_lock = 2'b10;
            end
            if (c == 20) bus2.i_lock = 2'b00;
            @(negedge clk);
            exp_g = (c >= 1 && c <= 20) ? 2'b10 : (c >= 22) ? 2'b01 : 2'b00;
            exp_p = (c == 21);
            checks++;
            if (bus2.o_gnt !== exp_g || bus2.o_preempt !== exp_p) begin
                failures++;
                $display("FAIL lock c%0d got gnt=%b pre=%b exp gnt=%b pre=%b",
                         c, bus2.o_gnt, bus2.o_preempt, exp_g, exp_p);
            end
            checks++;
            if (obs2 !== exp_vec(0)) begin
                failures++;
                $display("FAIL lock_model c%0d got=%h exp=%h", c, obs2, exp_vec(0));
            end
            tick();
        end
    endtask

    task automatic test_release();
        do_reset();
        bus2.i_req = 2'b11;
        for (int c = 0; c < 7; c++) begin
            if (c == 2) bus2.i_req = 2'b10;
            @(negedge clk);
            if (c == 3) begin
                checks++;
                if (bus2.o_gnt !== 2'b00 || bus2.o_preempt !== 1'b0 || bus2.o_busy !== 1'b1 ||
                    bus2.o_rsp_valid !== 1'b1 || bus2.o_rsp_sel !== 1'b0) begin
                    failures++;
                    $display("FAIL release_drain got gnt=%b pre=%b busy=%b rv=%b rs=%b exp gnt=00 pre=0 busy=1 rv=1 rs=0",
                             bus2.o_gnt, bus2.o_preempt, bus2.o_busy, bus2.o_rsp_valid, bus2.o_rsp_sel);
                end
            end
            if (c == 4) begin
                checks++;
                if (bus2.o_gnt !== 2'b10) begin
                    failures++;
                    $display("FAIL release_next got=%b exp=10", bus2.o_gnt);
                end
            end
            checks++;
            if (obs2 !== exp_vec(0)) begin
                failures++;
                $display("FAIL release_model c%0d got=%h exp=%h", c, obs2, exp_vec(0));
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus2.i_req = 2'b10;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (obs2 !== exp_vec(0)) begin
                failures++;
                $display("FAIL areset_pre c%0d got=%h exp=%h", c, obs2, exp_vec(0));
            end
            tick();
        end
        checks++;
        if (bus2.o_gnt !== 2'b10) begin
            failures++;
            $display("FAIL areset_owner got=%b exp=10", bus2.o_gnt);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs2 !== 15'b0) begin
            failures++;
            $display("FAIL areset_immediate got=%h exp=0", obs2);
        end
        model_reset();
        bus2.i_req = 2'b11;
        @(negedge clk);
        rst = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (bus2.o_gnt !== 2'b01) begin
                    failures++;
                    $display("FAIL areset_first got=%b exp=01", bus2.o_gnt);
                end
            end
            checks++;
            if (obs2 !== exp_vec(0)) begin
                failures++;
                $display("FAIL areset_model c%0d got=%h exp=%h", c, obs2, exp_vec(0));
            end
            tick();
        end
    endtask

    task automatic test_rotation();
        logic [2:0] exp_g;
        logic       exp_p;
        do_reset();
        bus3.i_req = 3'b111;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            exp_g = '0;
            exp_p = 1'b0;
            if (c % 2 == 1) exp_g = 3'b001 << (((c - 1) / 2) % 3);
            else if (c >= 2) exp_p = 1'b1;
            checks++;
            if (bus3.o_gnt !== exp_g || bus3.o_preempt !== exp_p) begin
                failures++;
                $display("FAIL rotation c%0d got gnt=%b pre=%b exp gnt=%b pre=%b",
                         c, bus3.o_gnt, bus3.o_preempt, exp_g, exp_p);
            end
            checks++;
            if (obs3 !== exp_vec(1)) begin
                failures++;
                $display("FAIL rotation_model c%0d got=%h exp=%h", c, obs3, exp_vec(1));
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(3) == 0) bus2.i_req  = 2'($urandom);
            if ($urandom_range(7) == 0) bus2.i_lock = 2'($urandom) & 2'($urandom);
            if ($urandom_range(3) == 0) bus3.i_req  = 3'($urandom);
            if ($urandom_range(7) == 0) bus3.i_lock = 3'($urandom) & 3'($urandom);
            @(negedge clk);
            checks++;
            if (obs2 !== exp_vec(0)) begin
                failures++;
                $display("FAIL random2 c%0d got=%h exp=%h", c, obs2, exp_vec(0));
            end
            checks++;
            if (obs3 !== exp_vec(1)) begin
                failures++;
                $display("FAIL random3 c%0d got=%h exp=%h", c, obs3, exp_vec(1));
            end
            tick();
        end
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        checks   = 0;
        failures = 0;
        model_reset();
        test_reset();
        test_single();
        test_hold_limit();
        test_lock();
        test_release();
        test_async_reset();
        test_rotation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
